frame_bank_reader: RTL and testbench

- Read-side counterpart of the pixel capture path: streams a stored WIDTH x HEIGHT frame back out of the four single-port 24-bit RAM banks (17-bit address) in raster order.
- Pixel index p = y*WIDTH + x lives in bank p[1:0]+1 at address p>>2; the writer uses the same mapping.
- Output is a valid/ready stream with frame/line markers, feeding the filter or display stage.
- Back-pressure is absorbed by a 2-entry output buffer, so RAM reads never need a stall path.

---
 rtl/frame_bank_reader.sv | 136 +++++++++++++
 tb/tb_frame_bank_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_reader.sv
// frame_bank_reader: streams a stored frame out of four single-port RAM banks in raster order
module frame_bank_reader #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300,
    parameter int AW     = 17,
    parameter int DW     = 24
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    output logic          oBUSY,
    output logic          oDONE,
    output logic [AW-1:0] oAddr1,
    output logic [AW-1:0] oAddr2,
    output logic [AW-1:0] oAddr3,
    output logic [AW-1:0] oAddr4,
    input  logic [DW-1:0] iData1,
    input  logic [DW-1:0] iData2,
    input  logic [DW-1:0] iData3,
    input  logic [DW-1:0] iData4,
    output logic          oDVAL,
    input  logic          iREADY,
    output logic [DW-1:0] oDATA,
    output logic          oSOF,
    output logic          oEOL,
    output logic          oEOF
);
    localparam int PW = AW + 2;
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [PW-1:0] LAST = PW'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_p;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_inflight;
    logic [1:0]      r_sel;
    logic [2:0]      r_fl;
    logic [DW+2:0]   r_buf [2];
    logic            r_wp, r_rp;
    logic [1:0]      r_cnt;
    logic            w_pop, w_issue, w_last, w_eol, w_empty;
    logic [2:0]      w_fl;
    logic [DW-1:0]   w_rdata;

    assign w_pop   = oDVAL & iREADY;
    assign w_last  = r_p == LAST;
    assign w_eol   = r_x == XMAX;
    assign w_empty = (r_cnt == 2'd0) & ~r_inflight;
    // Credit counts the slot freed by this cycle's handshake so a full-rate stream never stalls
    assign w_issue = (r_state == S_RUN) &&
                     (3'(r_cnt) + 3'(r_inflight) - 3'(w_pop) < 3'd2);
    assign w_fl    = {r_p == '0, w_eol, w_eol && (r_y == YMAX)};
    assign w_rdata = r_sel == 2'd0 ? iData1 :
                     r_sel == 2'd1 ? iData2 :
                     r_sel == 2'd2 ? iData3 : iData4;

    assign oAddr1 = r_p[PW-1:2];
    assign oAddr2 = r_p[PW-1:2];
    assign oAddr3 = r_p[PW-1:2];
    assign oAddr4 = r_p[PW-1:2];
    assign oDVAL  = r_cnt != 2'd0;
    assign {oDATA, oSOF, oEOL, oEOF} = r_buf[r_rp];

    // Next-state and handshake outputs; completion is flagged in the same cycle the FSM returns to idle
    always_comb begin
        w_next = r_state;
        oBUSY  = 1'b0;
        oDONE  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = iSTART ? S_RUN : S_IDLE;
            S_RUN: begin
                oBUSY  = 1'b1;
                w_next = (w_issue && w_last) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                oDONE  = w_empty;
                oBUSY  = ~w_empty;
                w_next = w_empty ? S_IDLE : S_DRAIN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, pixel pointer/counters and the single outstanding read tag
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_p        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_sel      <= '0;
            r_fl       <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_sel <= r_p[1:0];
                r_fl  <= w_fl;
            end
            if (r_state == S_IDLE && iSTART) begin
                r_p <= '0;
                r_x <= '0;
                r_y <= '0;
            end else if (w_issue && !w_last) begin
                r_p <= r_p + 1'b1;
                r_x <= w_eol ? '0 : r_x + 1'b1;
                r_y <= w_eol ? r_y + 1'b1 : r_y;
            end
        end
    end

    // Two-entry output FIFO capturing the bank word one cycle after its address
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_inflight) begin
                r_buf[r_wp] <= {w_rdata, r_fl};
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_frame_bank_reader.sv
// tb_frame_bank_reader: scoreboard bench for frame_bank_reader on a reduced frame
module tb_frame_bank_reader;
    localparam int W  = 20;
    localparam int H  = 15;
    localparam int N  = W * H;
    localparam int AW = 17;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          iRST = 1'b1, iSTART = 1'b0, iREADY = 1'b1;
    logic          oBUSY, oDONE, oDVAL, oSOF, oEOL, oEOF;
    logic [AW-1:0] oAddr1, oAddr2, oAddr3, oAddr4;
    logic [AW-1:0] ra1, ra2, ra3, ra4;
    logic [DW-1:0] iData1, iData2, iData3, iData4, oDATA;

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0, bmode = 0, ready_mode = 0;
    int hs_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
    logic [26:0] sb[$];

    frame_bank_reader #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DW(DW)) dut (
        .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .oBUSY(oBUSY), .oDONE(oDONE),
        .oAddr1(oAddr1), .oAddr2(oAddr2), .oAddr3(oAddr3), .oAddr4(oAddr4),
        .iData1(iData1), .iData2(iData2), .iData3(iData3), .iData4(iData4),
        .oDVAL(oDVAL), .iREADY(iREADY), .oDATA(oDATA),
        .oSOF(oSOF), .oEOL(oEOL), .oEOF(oEOF)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank models: one-cycle read latency, content chosen by bmode
    always @(posedge clk) begin
        ra1 <= oAddr1;
        ra2 <= oAddr2;
        ra3 <= oAddr3;
        ra4 <= oAddr4;
    end
    assign iData1 = bmode != 0 ? (24'd1 << 20) | 24'(ra1) : 24'({ra1, 2'd0});
    assign iData2 = bmode != 0 ? (24'd2 << 20) | 24'(ra2) : 24'({ra2, 2'd1});
    assign iData3 = bmode != 0 ? (24'd3 << 20) | 24'(ra3) : 24'({ra3, 2'd2});
    assign iData4 = bmode != 0 ? (24'd4 << 20) | 24'(ra4) : 24'({ra4, 2'd3});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled
    initial forever begin
        @(posedge clk);
        #1;
        iREADY = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability
    initial begin
        logic        hold;
        logic [26:0] held, exp;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_dval", 32'(oDVAL), 32'd1);
                chk("hold_data", 32'({oDATA, oSOF, oEOL, oEOF}), 32'(held));
            end
            hold = oDVAL && !iREADY;
            held = {oDATA, oSOF, oEOL, oEOF};
            if (oDONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (oDVAL && iREADY) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel act=%0h exp=none", oDATA);
                end else begin
                    exp = sb.pop_front();
                    chk("pixel", 32'({oDATA, oSOF, oEOL, oEOF}), 32'(exp));
                end
                if (hs_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                hs_cnt++;
            end
        end
    end

    task automatic start_frame(input int mode);
        logic [23:0] d;
        bmode    = mode;
        hs_cnt   = 0;
        done_cnt = 0;
        for (int p = 0; p < N; p++) begin
            d = mode != 0 ? 24'(((p % 4 + 1) << 20) | (p / 4)) : 24'(p);
            sb.push_back({d, p == 0, p % W == W - 1, p == N - 1});
        end
        @(posedge clk);
        #1;
        iSTART = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        iSTART = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(oBUSY), 32'd1);
    endtask

    task automatic wait_hs(input int k);
        int n = 0;
        while (hs_cnt < k && n < 4 * N) begin
            @(posedge clk);
            n++;
        end
        if (hs_cnt < k) chk("hs_timeout", 32'(hs_cnt), 32'(k));
    endtask

    task automatic finish_frame();
        int n = 0;
        while (done_cnt == 0 && n < 4 * N + 50) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 32'(done_cnt), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("busy_after_done", 32'(oBUSY), 32'd0);
        chk("dval_after_done", 32'(oDVAL), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_dval", 32'(oDVAL), 32'd0);
        chk("rst_flags", 32'({oSOF, oEOL, oEOF}), 32'd0);
        chk("rst_addr", 32'(oAddr1), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        @(posedge clk);
        #1;
        iRST = 1'b0;

        // Full-rate frame: latency and throughput
        ready_mode = 0;
        start_frame(0);
        finish_frame();
        chk("first_latency", 32'(first_cyc - t0), 32'd3);
        chk("last_spacing", 32'(last_cyc - first_cyc), 32'(N - 1));
        chk("done_after_last", 32'(done_cyc - last_cyc), 32'd1);

        // Random back-pressure
        ready_mode = 1;
        start_frame(0);
        finish_frame();

        // Fully stalled downstream: two pixels buffered, pointer parked at address 0
        ready_mode = 2;
        start_frame(0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_dval", 32'(oDVAL), 32'd1);
        chk("stall_data", 32'(oDATA), 32'd0);
        chk("stall_sof", 32'(oSOF), 32'd1);
        chk("stall_addr", 32'(oAddr1), 32'd0);
        chk("stall_addr4", 32'(oAddr4), 32'd0);
        chk("stall_hs", 32'(hs_cnt), 32'd0);
        ready_mode = 0;
        finish_frame();

        // Second start while busy is ignored
        start_frame(0);
        wait_hs(50);
        @(posedge clk);
        #1;
        iSTART = 1'b1;
        @(posedge clk);
        #1;
        iSTART = 1'b0;
        finish_frame();

        // Reset mid-frame aborts, then a fresh frame restarts at pixel 0
        start_frame(0);
        wait_hs(150);
        @(posedge clk);
        #1;
        iRST = 1'b1;
        @(posedge clk);
        #1;
        iRST = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_dval", 32'(oDVAL), 32'd0);
        chk("abort_busy", 32'(oBUSY), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_quiet", 32'(oDVAL), 32'd0);
        end
        ready_mode = 1;
        start_frame(0);
        finish_frame();

        // Bank mapping with bank-tagged contents
        start_frame(1);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
